// File: rtl/data_bus_pkg.sv
// data_bus_pkg
//   Shared definitions for the data-bus arbiter slice:
//   - legal data-region base/limit addresses (SRAM0, SRAM1, Control Module, UART1)
//   - sequencer state encoding
//   - wait-counter and requester-index widths
//   - addr_in_region(): address decode check, used only when the
//     DATA_BUS_DECODE_ERR_EN build option is defined
package data_bus_pkg;

  localparam int CNT_W = 4;  // wait counter width, holds 1..15
  localparam int IDX_W = 2;  // requester index width, up to 4 requesters

  localparam logic [31:0] SRAM0_BASE  = 32'h1000_0000;
  localparam logic [31:0] SRAM0_LIMIT = 32'h13FF_FFFF;
  localparam logic [31:0] SRAM1_BASE  = 32'h1400_0000;
  localparam logic [31:0] SRAM1_LIMIT = 32'h17FF_FFFF;
  localparam logic [31:0] CTRL_BASE   = 32'h44E1_0000;
  localparam logic [31:0] CTRL_LIMIT  = 32'h44E1_1FFF;
  localparam logic [31:0] UART1_BASE  = 32'h4802_2000;
  localparam logic [31:0] UART1_LIMIT = 32'h4802_2FFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    ERROR  = 2'd3
  } state_t;

  function automatic logic addr_in_region(input logic [31:0] a);
    return ((a >= SRAM0_BASE) && (a <= SRAM0_LIMIT)) ||
           ((a >= SRAM1_BASE) && (a <= SRAM1_LIMIT)) ||
           ((a >= CTRL_BASE)  && (a <= CTRL_LIMIT))  ||
           ((a >= UART1_BASE) && (a <= UART1_LIMIT));
  endfunction

endpackage

// File: rtl/data_bus_arbiter_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin selector. The search starts at index
//   ptr and wraps, so the first requester at or after ptr wins.
//   Ports:
//     req     in  NREQ   request levels
//     ptr     in  IDX_W  highest-priority index this round
//     win     out NREQ   one-hot winner (all zero when no request)
//     win_idx out IDX_W  binary index of the winner (0 when no request)
module rr_arbiter
  import data_bus_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  win,
  output logic [IDX_W-1:0] win_idx
);

  logic found;

  always_comb begin
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    // Offset o is the priority rank; the inner loop locates the requester
    // sitting at rank o without indexing by a variable.
    for (int o = 0; o < NREQ; o++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == ((int'(ptr) + o) % NREQ))) begin
          found   = 1'b1;
          win[i]  = 1'b1;
          win_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Round-robin arbiter and access sequencer for the shared data bus
//   (SRAM0, SRAM1, Control Module, UART1 decode). A winner's address and
//   rd/wr qualifiers are latched at grant, the strobes are held for
//   WAIT_CYCLES cycles, then a one-cycle ack (or err for a malformed
//   request) is returned with gnt still high.
//   Build option: DATA_BUS_DECODE_ERR_EN -- when defined, addresses outside
//   the four legal regions take the error path instead of the bus.
//   Ports:
//     clk      in  1        system clock, rising edge
//     nRESET   in  1        asynchronous active-low reset
//     req      in  NREQ     request levels
//     req_addr in  NREQ*32  request addresses, requester i at [32*i+31:32*i]
//     req_rd   in  NREQ     read qualifiers
//     req_wr   in  NREQ     write qualifiers
//     gnt      out NREQ     one-hot grant, held through ack/err
//     ack      out NREQ     one-cycle completion pulse
//     err      out NREQ     one-cycle error pulse (no bus access made)
//     address  out 32       shared bus address
//     read     out 1        shared read strobe
//     write    out 1        shared write strobe
//     busy     out 1        sequencer not in IDLE
module data_bus_arbiter
  import data_bus_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               nRESET,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*32-1:0] req_addr,
  input  logic [NREQ-1:0]    req_rd,
  input  logic [NREQ-1:0]    req_wr,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    err,
  output logic [31:0]        address,
  output logic               read,
  output logic               write,
  output logic               busy
);

  state_t            state_reg, state_next;
  logic [NREQ-1:0]   gnt_reg, gnt_next;
  logic [NREQ-1:0]   ack_reg, ack_next;
  logic [NREQ-1:0]   err_reg, err_next;
  logic [31:0]       addr_reg, addr_next;
  logic              read_reg, read_next;
  logic              write_reg, write_next;
  logic              busy_reg, busy_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  ptr_reg, ptr_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;

  logic [NREQ-1:0]   win;
  logic [IDX_W-1:0]  win_idx;
  logic [31:0]       addr_arr [NREQ];
  logic [31:0]       addr_sel;
  logic              win_rd;
  logic              win_wr;
  logic              region_ok;
  logic [IDX_W-1:0]  ptr_adv;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr_slice
      assign addr_arr[gi] = req_addr[32*gi +: 32];
    end
  endgenerate

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req     (req),
    .ptr     (ptr_reg),
    .win     (win),
    .win_idx (win_idx)
  );

  // One-hot AND-OR select of the winner's address and qualifiers.
  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) addr_sel = addr_arr[i];
    end
  end

  assign win_rd = |(win & req_rd);
  assign win_wr = |(win & req_wr);

`ifdef DATA_BUS_DECODE_ERR_EN
  assign region_ok = addr_in_region(addr_sel);
`else
  assign region_ok = 1'b1;
`endif

  // Pointer moves just past the requester that was served.
  assign ptr_adv = (idx_reg == IDX_W'(NREQ - 1)) ? '0 : idx_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    ack_next   = '0;
    err_next   = '0;
    addr_next  = addr_reg;
    read_next  = read_reg;
    write_next = write_reg;
    cnt_next   = cnt_reg;
    ptr_next   = ptr_reg;
    idx_next   = idx_reg;

    case (state_reg)
      IDLE: begin
        // gnt from the previous transaction is held through its ack/err
        // cycle and released (or replaced) here.
        gnt_next = '0;
        if (|req) begin
          gnt_next  = win;
          idx_next  = win_idx;
          addr_next = addr_sel;
          cnt_next  = CNT_W'(WAIT_CYCLES);
          if ((win_rd ^ win_wr) && region_ok) begin
            read_next  = win_rd;
            write_next = win_wr;
            state_next = ACCESS;
          end else begin
            state_next = ERROR;
          end
        end
      end
      ACCESS: begin
        if (cnt_reg <= CNT_W'(1)) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      DONE: begin
        ack_next   = gnt_reg;
        ptr_next   = ptr_adv;
        state_next = IDLE;
      end
      ERROR: begin
        err_next   = gnt_reg;
        ptr_next   = ptr_adv;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      ack_reg   <= '0;
      err_reg   <= '0;
      addr_reg  <= 32'h0000_0000;
      read_reg  <= 1'b0;
      write_reg <= 1'b0;
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      ptr_reg   <= '0;
      idx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      addr_reg  <= addr_next;
      read_reg  <= read_next;
      write_reg <= write_next;
      busy_reg  <= busy_next;
      cnt_reg   <= cnt_next;
      ptr_reg   <= ptr_next;
      idx_reg   <= idx_next;
    end
  end

  assign gnt     = gnt_reg;
  assign ack     = ack_reg;
  assign err     = err_reg;
  assign address = addr_reg;
  assign read    = read_reg;
  assign write   = write_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter
//   Directed test of data_bus_arbiter with NREQ=2, WAIT_CYCLES=2.
module tb_data_bus_arbiter;

  logic        clk = 1'b0;
  logic        nRESET;
  logic [1:0]  req;
  logic [63:0] req_addr;
  logic [1:0]  req_rd;
  logic [1:0]  req_wr;
  logic [1:0]  gnt;
  logic [1:0]  ack;
  logic [1:0]  err;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  data_bus_arbiter #(.NREQ(2), .WAIT_CYCLES(2)) dut (
    .clk      (clk),
    .nRESET   (nRESET),
    .req      (req),
    .req_addr (req_addr),
    .req_rd   (req_rd),
    .req_wr   (req_wr),
    .gnt      (gnt),
    .ack      (ack),
    .err      (err),
    .address  (address),
    .read     (read),
    .write    (write),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    nRESET   = 1'b0;
    req      = '0;
    req_addr = '0;
    req_rd   = '0;
    req_wr   = '0;

    // Reset state
    tick(); tick();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_addr", address, 32'h0);
    chk("rst_read", 32'(read), 32'h0);
    chk("rst_write", 32'(write), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    nRESET = 1'b1;
    tick();
    $display("reset released");

    // Single read, requester 0
    req_addr = {32'h0, 32'h1000_08AD};
    req_rd = 2'b01; req_wr = 2'b00; req = 2'b01;
    tick(); req = 2'b00;
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_addr", address, 32'h1000_08AD);
    chk("rd_read1", 32'(read), 32'h1);
    chk("rd_write1", 32'(write), 32'h0);
    chk("rd_busy", 32'(busy), 32'h1);
    tick();
    chk("rd_read2", 32'(read), 32'h1);
    chk("rd_addr2", address, 32'h1000_08AD);
    tick();
    chk("rd_read_off", 32'(read), 32'h0);
    chk("rd_ack_early", 32'(ack), 32'h0);
    tick();
    chk("rd_ack", 32'(ack), 32'h1);
    chk("rd_gnt_hold", 32'(gnt), 32'h1);
    chk("rd_write_never", 32'(write), 32'h0);
    tick();
    chk("rd_ack_clear", 32'(ack), 32'h0);
    chk("rd_gnt_clear", 32'(gnt), 32'h0);
    $display("single read requester 0 done");

    // Illegal request, requester 1 (rd=wr=1); pointer was 1, must go to 0
    req_addr = {32'h1000_0010, 32'h0};
    req_rd = 2'b10; req_wr = 2'b10; req = 2'b10;
    tick(); req = 2'b00;
    chk("ill_gnt", 32'(gnt), 32'h2);
    chk("ill_read", 32'(read), 32'h0);
    chk("ill_write", 32'(write), 32'h0);
    chk("ill_err_early", 32'(err), 32'h0);
    tick();
    chk("ill_err", 32'(err), 32'h2);
    chk("ill_read2", 32'(read), 32'h0);
    chk("ill_write2", 32'(write), 32'h0);
    chk("ill_ack", 32'(ack), 32'h0);
    tick();
    chk("ill_err_clear", 32'(err), 32'h0);
    req_addr = {32'h1400_0020, 32'h1000_0040};
    req_rd = 2'b11; req_wr = 2'b00; req = 2'b11;
    tick(); req = 2'b00;
    chk("ill_ptr_gnt", 32'(gnt), 32'h1);
    repeat (4) tick();
    $display("illegal request requester 1 done");

    // Write to 0x2000_0FFA (outside every region); pointer is 1
    req_addr = {32'h0, 32'h2000_0FFA};
    req_rd = 2'b00; req_wr = 2'b01; req = 2'b01;
    tick(); req = 2'b00;
`ifdef DATA_BUS_DECODE_ERR_EN
    chk("dec_gnt", 32'(gnt), 32'h1);
    chk("dec_write", 32'(write), 32'h0);
    tick();
    chk("dec_err", 32'(err), 32'h1);
    chk("dec_write2", 32'(write), 32'h0);
    tick();
    $display("write to unmapped address rejected");
    req_addr = {32'h0, 32'h4802_2C58};
    req_rd = 2'b00; req_wr = 2'b01; req = 2'b01;
    tick(); req = 2'b00;
`endif
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_write1", 32'(write), 32'h1);
    chk("wr_read", 32'(read), 32'h0);
    tick();
    chk("wr_write2", 32'(write), 32'h1);
    tick();
    chk("wr_write_off", 32'(write), 32'h0);
    tick();
    chk("wr_ack", 32'(ack), 32'h1);
    chk("wr_err", 32'(err), 32'h0);
    tick();
    $display("write access done");

    // Asynchronous reset during ACCESS of requester 1; pointer was 1
    req_addr = {32'h1400_0000, 32'h0};
    req_rd = 2'b10; req_wr = 2'b00; req = 2'b10;
    tick(); req = 2'b00;
    chk("abort_gnt", 32'(gnt), 32'h2);
    chk("abort_read", 32'(read), 32'h1);
    #1 nRESET = 1'b0;
    #1;
    chk("abort_gnt0", 32'(gnt), 32'h0);
    chk("abort_read0", 32'(read), 32'h0);
    chk("abort_addr0", address, 32'h0);
    chk("abort_busy0", 32'(busy), 32'h0);
    tick();
    chk("abort_ack_rst", 32'(ack), 32'h0);
    nRESET = 1'b1;
    tick();
    chk("abort_ack_after", 32'(ack), 32'h0);
    chk("abort_gnt_after", 32'(gnt), 32'h0);
    req_addr = {32'h1400_0000, 32'h1000_0000};
    req_rd = 2'b11; req_wr = 2'b00; req = 2'b11;
    tick(); req = 2'b00;
    chk("abort_first_gnt", 32'(gnt), 32'h1);
    repeat (4) tick();
    $display("reset during access done");

    // Round robin from reset with both requesting continuously
    nRESET = 1'b0;
    tick();
    nRESET = 1'b1;
    tick();
    req_addr = {32'h1400_0100, 32'h1000_0200};
    req_rd = 2'b11; req_wr = 2'b00; req = 2'b11;
    tick();
    chk("rr_gnt0", 32'(gnt), 32'h1);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("rr_onehot", 32'($onehot0(gnt)), 32'h1);
      if (i == 3) chk("rr_ack0", 32'(ack), 32'h1);
      if (i == 4) begin
        chk("rr_gnt1", 32'(gnt), 32'h2);
        chk("rr_addr1", address, 32'h1400_0100);
      end
      if (i == 7) chk("rr_ack1", 32'(ack), 32'h2);
      if (i == 8) chk("rr_gnt2", 32'(gnt), 32'h1);
    end
    req = 2'b00;
    repeat (5) tick();
    $display("round robin done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
